// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_unit_pkg : op encodings, default latencies and FSM state type
// Revision 1.0
// ============================================================================
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// mdu_calc : combinational 64-bit product and quotient/remainder for the MDU
// Revision 1.0
// ============================================================================
module mdu_calc
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        w_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed variants (mult, div) have op[0] clear.
  assign w_signed = ~op[0];
  assign w_neg_a  = w_signed & a[31];
  assign w_neg_b  = w_signed & b[31];
  assign w_mag_a  = w_neg_a ? (~a + 32'd1) : a;
  assign w_mag_b  = w_neg_b ? (~b + 32'd1) : b;
  assign w_div_b  = (b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q      = w_mag_a / w_div_b;
  assign w_r      = w_mag_a % w_div_b;
  // 0x8000_0000 / -1 wraps back to 0x8000_0000 through the negate, remainder 0.
  assign w_q_s    = (w_neg_a ^ w_neg_b) ? (~w_q + 32'd1) : w_q;
  assign w_r_s    = w_neg_a ? (~w_r + 32'd1) : w_r;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MDU_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = w_r_s;
          res_lo = w_q_s;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : multi-cycle multiply/divide unit with HI/LO registers
// Revision 1.0
// ============================================================================
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_pend_hi;
  logic [31:0]        r_pend_lo;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               r_done;
  logic [31:0]        w_calc_hi;
  logic [31:0]        w_calc_lo;

  mdu_calc u_calc (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (w_calc_hi),
    .res_lo (w_calc_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              MDU_MULT, MDU_MULTU: begin
                r_pend_hi <= w_calc_hi;
                r_pend_lo <= w_calc_lo;
                r_cnt     <= CNT_W'(MUL_LAT);
                r_state   <= ST_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                r_pend_hi <= w_calc_hi;
                r_pend_lo <= w_calc_lo;
                r_cnt     <= CNT_W'(DIV_LAT);
                r_state   <= ST_RUN;
              end
              MDU_MTHI: r_hi <= a;
              MDU_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Any start seen here is deliberately dropped; the stall unit owns that hazard.
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : directed self-checking bench for mult_div_unit
// Revision 1.0
// ============================================================================
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
  endtask

  // Counts busy cycles while HI/LO must hold; intr>0 pulses mtlo 0x1234 in that RUN cycle.
  task automatic wait_commit(input string tag, input int lat, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int intr);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      check({tag, "_hold_hi"}, hi, m_hi);
      check({tag, "_hold_lo"}, lo, m_lo);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      if (n == intr) begin
        start = 1'b1;
        op    = MDU_MTLO;
        a     = 32'h0000_1234;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(lat));
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(o, av, bv);
    wait_commit(tag, lat, exp_hi, exp_lo, 0);
    tick();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic seen_done;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    run_op("mult_m2x3",  MDU_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("mult_m1xm1", MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001);
    run_op("mult_max",   MDU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001);
    run_op("div_m7d2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",   MDU_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_7d2",   MDU_DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3);
    run_op("divu_big",   MDU_DIVU,  32'hFFFF_FFF9, 32'd2,         10, 32'd1,         32'h7FFF_FFFC);
    run_op("divu_by0",   MDU_DIVU,  32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);
    run_op("div_by0",    MDU_DIV,   32'hFFFF_FFF9, 32'd0,         10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",    MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);

    // multu with an mtlo pulse in RUN cycle 2 that must be ignored
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_commit("multu_intr", 5, 32'hFFFF_FFFE, 32'h0000_0001, 2);
    tick();
    check("multu_intr_lo_after", lo, 32'h0000_0001);
    check("multu_intr_busy_after", {31'd0, busy}, 32'd0);

    // reset three cycles into a div
    issue(MDU_DIV, 32'd100, 32'd7);
    tick();
    tick();
    check("rstrun_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstrun_busy", {31'd0, busy}, 32'd0);
    check("rstrun_done", {31'd0, done}, 32'd0);
    check("rstrun_hi", hi, 32'd0);
    check("rstrun_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("rstrun_never_done", {31'd0, seen_done}, 32'd0);

    // back-to-back: mult issued in the done cycle of a div
    issue(MDU_DIV, 32'd100, 32'd7);
    wait_commit("b2b_div", 10, 32'd2, 32'd14, 0);
    issue(MDU_MULT, 32'd6, 32'd7);
    check("b2b_busy_next", {31'd0, busy}, 32'd1);
    wait_commit("b2b_mult", 5, 32'd0, 32'd42, 0);
    tick();
    check("b2b_done_drop", {31'd0, done}, 32'd0);

    issue(MDU_MTHI, 32'h0000_ABCD, 32'd0);
    check("mthi_hi", hi, 32'h0000_ABCD);
    check("mthi_lo", lo, 32'd42);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    issue(MDU_MTLO, 32'h5555_AAAA, 32'd0);
    check("mtlo_lo", lo, 32'h5555_AAAA);
    check("mtlo_hi", hi, 32'h0000_ABCD);

    // reserved ops leave everything alone
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("rsv6_busy", {31'd0, busy}, 32'd0);
    check("rsv6_hi", hi, 32'h0000_ABCD);
    check("rsv6_lo", lo, 32'h5555_AAAA);
    issue(3'd7, 32'h3333_3333, 32'h4444_4444);
    tick();
    check("rsv7_busy", {31'd0, busy}, 32'd0);
    check("rsv7_done", {31'd0, done}, 32'd0);
    check("rsv7_hi", hi, 32'h0000_ABCD);
    check("rsv7_lo", lo, 32'h5555_AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
